// File: rtl/vga_scan_driver.sv
// Raster timing generator for the 640x480@60 path: issues map coordinates,
// realigns blank/sync with the returned map colour and drives the VGA pins.
module vga_scan_driver #(
    parameter int MAP_LATENCY = 1,
    parameter int H_VIS       = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VIS       = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33
) (
    input  logic       clk_vga,
    input  logic       rst,
    output logic [9:0] CurrentX,
    output logic [8:0] CurrentY,
    input  logic [7:0] mapData,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] C_H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] C_V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] C_H_VIS  = 10'(H_VIS);
    localparam logic [9:0] C_V_VIS  = 10'(V_VIS);
    localparam logic [9:0] C_HS_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] C_HS_END = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] C_VS_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] C_VS_END = 10'(V_VIS + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic vis;
        logic hs_n;
        logic vs_n;
        logic fs;
    } strobe_t;

    localparam strobe_t IDLE = '{vis: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [9:0] r_cur_x;
    logic [8:0] r_cur_y;
    logic       w_h_last;
    logic       w_v_last;
    logic       w_y_vis;
    strobe_t    w_raw;
    strobe_t    w_align;
    strobe_t    r_pipe [MAP_LATENCY + 1];
    logic [7:0] r_rgb;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_fs;

    assign w_h_last = (r_hcount == C_H_LAST);
    assign w_v_last = (r_vcount == C_V_LAST);
    assign w_y_vis  = (r_vcount < C_V_VIS);

    // Both counters return to 0 on the same edge at the end of the frame.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_hcount <= '0;
            r_vcount <= '0;
        end else if (w_h_last) begin
            r_hcount <= '0;
            r_vcount <= w_v_last ? '0 : r_vcount + 10'd1;
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    always_comb begin
        w_raw      = IDLE;
        w_raw.vis  = (r_hcount < C_H_VIS) && w_y_vis;
        w_raw.hs_n = !((r_hcount >= C_HS_BEG) && (r_hcount <= C_HS_END));
        w_raw.vs_n = !((r_vcount >= C_VS_BEG) && (r_vcount <= C_VS_END));
        w_raw.fs   = (r_hcount == '0) && (r_vcount == '0);
    end

    // Y is clamped in vertical blanking so the 9-bit bus never aliases.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_cur_x <= '0;
            r_cur_y <= '0;
        end else begin
            r_cur_x <= r_hcount;
            r_cur_y <= w_y_vis ? r_vcount[8:0] : 9'd0;
        end
    end

    // Stage 0 sits beside the coordinates; the last stage meets mapData.
    always_ff @(posedge clk_vga) begin
        if (rst) begin
            for (int i = 0; i <= MAP_LATENCY; i++) begin
                r_pipe[i] <= IDLE;
            end
        end else begin
            r_pipe[0] <= w_raw;
            for (int i = 1; i <= MAP_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_align = r_pipe[MAP_LATENCY];

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            r_rgb   <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_fs    <= 1'b0;
        end else begin
            r_rgb   <= w_align.vis ? mapData : 8'h00;
            r_hsync <= w_align.hs_n;
            r_vsync <= w_align.vs_n;
            r_fs    <= w_align.fs;
        end
    end

    assign CurrentX    = r_cur_x;
    assign CurrentY    = r_cur_y;
    assign red         = r_rgb[7:5];
    assign green       = r_rgb[4:2];
    assign blue        = r_rgb[1:0];
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: three instances (latency 1/3/2, shortened
// vertical timing) checked each cycle against an arithmetic raster model.
module tb_vga_scan_driver;

    logic       clk;
    logic       rst;
    logic [7:0] mapA, mapB, mapC;

    logic [9:0] A_x, B_x, C_x;
    logic [8:0] A_y, B_y, C_y;
    logic       A_hs, A_vs, A_fs, B_hs, B_vs, B_fs, C_hs, C_vs, C_fs;
    logic [2:0] A_r, A_g, B_r, B_g, C_r, C_g;
    logic [1:0] A_b, B_b, C_b;

    logic [31:0] oA, oB, oC;
    assign oA = {2'b00, A_x, A_y, A_hs, A_vs, A_r, A_g, A_b, A_fs};
    assign oB = {2'b00, B_x, B_y, B_hs, B_vs, B_r, B_g, B_b, B_fs};
    assign oC = {2'b00, C_x, C_y, C_hs, C_vs, C_r, C_g, C_b, C_fs};

    vga_scan_driver #(.MAP_LATENCY(1), .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(1)) uA (
        .clk_vga(clk), .rst(rst), .CurrentX(A_x), .CurrentY(A_y),
        .mapData(mapA), .hsync(A_hs), .vsync(A_vs), .red(A_r),
        .green(A_g), .blue(A_b), .frame_start(A_fs));

    vga_scan_driver #(.MAP_LATENCY(3), .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(2)) uB (
        .clk_vga(clk), .rst(rst), .CurrentX(B_x), .CurrentY(B_y),
        .mapData(mapB), .hsync(B_hs), .vsync(B_vs), .red(B_r),
        .green(B_g), .blue(B_b), .frame_start(B_fs));

    vga_scan_driver #(.MAP_LATENCY(2), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
                      .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3)) uC (
        .clk_vga(clk), .rst(rst), .CurrentX(C_x), .CurrentY(C_y),
        .mapData(mapC), .hsync(C_hs), .vsync(C_vs), .red(C_r),
        .green(C_g), .blue(C_b), .frame_start(C_fs));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int n = 0;
    int ka = 0;
    int kb = 0;
    logic [7:0] kc = 8'h00;

    logic [9:0] hxA [4], hxB [4], hxC [4];
    logic [8:0] hyA [4], hyB [4], hyC [4];

    typedef struct {
        int         n;
        logic [9:0] x;
        logic [8:0] y;
        logic       hs;
        logic       vs;
        logic       fs;
        logic [7:0] rgb;
    } vec_t;

    vec_t tbl [18];

    task automatic finish_tb();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h (n=%0d)", nm, act, expv, n);
            if (failures >= 40) finish_tb();
        end
    endtask

    // Map colour as a pure function of the coordinate.
    function automatic logic [7:0] pix(input int kind, input int x, input int y);
        if (kind == 1) return 8'(x);
        return 8'(x * ka + y * kb) ^ kc;
    endfunction

    // Outputs after n clean edges since reset: coordinate of raster index n-1,
    // pins showing raster index n-L-2.
    function automatic logic [31:0] model(input int nn, input int L,
                                          input int hv, input int hf, input int hs, input int hb,
                                          input int vv, input int vf, input int vs, input int vb,
                                          input int kind);
        int ht, vt, t, x, y;
        logic [9:0] cx;
        logic [8:0] cy;
        logic h, v, f;
        logic [7:0] p;
        ht = hv + hf + hs + hb;
        vt = vv + vf + vs + vb;
        cx = '0; cy = '0; h = 1'b1; v = 1'b1; f = 1'b0; p = 8'h00;
        if (nn > 0) begin
            t = nn - 1;
            x = t % ht;
            y = (t / ht) % vt;
            cx = 10'(x);
            cy = (y < vv) ? 9'(y) : 9'd0;
        end
        t = nn - L - 2;
        if (t >= 0) begin
            x = t % ht;
            y = (t / ht) % vt;
            h = !(x >= hv + hf && x < hv + hf + hs);
            v = !(y >= vv + vf && y < vv + vf + vs);
            f = (x == 0 && y == 0);
            if (x < hv && y < vv) p = pix(kind, x, y);
        end
        return {2'b00, cx, cy, h, v, p, f};
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) n = 0;
        else n++;
        #1;
        chk("modelA", oA, model(n, 1, 640, 16, 96, 48, 4, 1, 2, 1, 0));
        chk("modelB", oB, model(n, 3, 640, 16, 96, 48, 3, 1, 1, 2, 1));
        chk("modelC", oC, model(n, 2, 16, 2, 4, 3, 6, 2, 2, 3, 0));
        for (int k = 3; k > 0; k--) begin
            hxA[k] = hxA[k-1]; hyA[k] = hyA[k-1];
            hxB[k] = hxB[k-1]; hyB[k] = hyB[k-1];
            hxC[k] = hxC[k-1]; hyC[k] = hyC[k-1];
        end
        hxA[0] = A_x; hyA[0] = A_y;
        hxB[0] = B_x; hyB[0] = B_y;
        hxC[0] = C_x; hyC[0] = C_y;
        mapA = pix(0, int'(hxA[1]), int'(hyA[1]));
        mapB = pix(1, int'(hxB[3]), int'(hyB[3]));
        mapC = pix(0, int'(hxC[2]), int'(hyC[2]));
    endtask

    task automatic do_reset(input int cycles, input int a, input int b, input logic [7:0] c);
        rst = 1'b1;
        ka = a; kb = b; kc = c;
        repeat (cycles) step();
        rst = 1'b0;
    endtask

    task automatic wait_x(input logic [9:0] target);
        for (int i = 0; i < 2000 && A_x != target; i++) step();
        chk("reach_x", 32'(A_x), 32'(target));
    endtask

    int cnt, vlow, per;

    initial begin
        tbl[0]  = '{1,    10'd0,   9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[1]  = '{2,    10'd1,   9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{3,    10'd2,   9'd0, 1'b1, 1'b1, 1'b1, 8'hB6};
        tbl[3]  = '{4,    10'd3,   9'd0, 1'b1, 1'b1, 1'b0, 8'hB6};
        tbl[4]  = '{642,  10'd641, 9'd0, 1'b1, 1'b1, 1'b0, 8'hB6};
        tbl[5]  = '{643,  10'd642, 9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[6]  = '{658,  10'd657, 9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[7]  = '{659,  10'd658, 9'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[8]  = '{754,  10'd753, 9'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{755,  10'd754, 9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[10] = '{801,  10'd0,   9'd1, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[11] = '{803,  10'd2,   9'd1, 1'b1, 1'b1, 1'b0, 8'hB6};
        tbl[12] = '{1603, 10'd2,   9'd2, 1'b1, 1'b1, 1'b0, 8'hB6};
        tbl[13] = '{3201, 10'd0,   9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[14] = '{4003, 10'd2,   9'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[15] = '{5602, 10'd1,   9'd0, 1'b1, 1'b0, 1'b0, 8'h00};
        tbl[16] = '{5603, 10'd2,   9'd0, 1'b1, 1'b1, 1'b0, 8'h00};
        tbl[17] = '{6403, 10'd2,   9'd0, 1'b1, 1'b1, 1'b1, 8'hB6};

        for (int k = 0; k < 4; k++) begin
            hxA[k] = '0; hyA[k] = '0; hxB[k] = '0;
            hyB[k] = '0; hxC[k] = '0; hyC[k] = '0;
        end
        rst = 1'b1;
        mapA = 8'h00; mapB = 8'h00; mapC = 8'h00;

        // Constant colour 8'b10110110 through the table vectors.
        do_reset(2, 0, 0, 8'hB6);
        for (int i = 0; i < 18; i++) begin
            for (int j = 0; j < 7000 && n < tbl[i].n; j++) step();
            chk("tbl_n", 32'(n), 32'(tbl[i].n));
            chk("tbl_x", 32'(A_x), 32'(tbl[i].x));
            chk("tbl_y", 32'(A_y), 32'(tbl[i].y));
            chk("tbl_hs", 32'(A_hs), 32'(tbl[i].hs));
            chk("tbl_vs", 32'(A_vs), 32'(tbl[i].vs));
            chk("tbl_fs", 32'(A_fs), 32'(tbl[i].fs));
            chk("tbl_rgb", 32'({A_r, A_g, A_b}), 32'(tbl[i].rgb));
        end

        // Mid-line reset for 3 cycles, then the coordinate restart.
        wait_x(10'd300);
        rst = 1'b1;
        step();
        chk("rst_hs", 32'(A_hs), 32'd1);
        chk("rst_vs", 32'(A_vs), 32'd1);
        chk("rst_rgb", 32'({A_r, A_g, A_b}), 32'd0);
        chk("rst_x", 32'(A_x), 32'd0);
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("rel_x", 32'(A_x), 32'(i));
        end

        // hsync edge delay, width and period.
        wait_x(10'd656);
        cnt = 0;
        while (A_hs !== 1'b0 && cnt < 10) begin step(); cnt++; end
        chk("hs_delay", 32'(cnt), 32'd2);
        cnt = 0;
        while (A_hs === 1'b0 && cnt < 900) begin step(); cnt++; end
        chk("hs_width", 32'(cnt), 32'd96);
        per = cnt;
        while (A_hs !== 1'b0 && per < 1700) begin step(); per++; end
        chk("hs_period", 32'(per), 32'd800);

        // Two frames: frame_start period and vsync low time.
        cnt = 0;
        while (A_fs !== 1'b1 && cnt < 7000) begin step(); cnt++; end
        chk("fs_seen", 32'(A_fs), 32'd1);
        for (int f = 0; f < 2; f++) begin
            per = 0;
            vlow = 0;
            do begin
                step();
                per++;
                if (A_vs === 1'b0) vlow++;
            end while (A_fs !== 1'b1 && per < 7000);
            chk("fs_period", 32'(per), 32'd6400);
            chk("vs_low", 32'(vlow), 32'd1600);
        end

        // Map returns all ones: blanking must still force RGB to 0.
        do_reset(2, 0, 0, 8'hFF);
        repeat (6500) step();

        // Random colour functions with random reset pulses.
        do_reset(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)));
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 999) < 3) begin
                do_reset(int'($urandom_range(1, 3)), int'($urandom_range(0, 255)),
                         int'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            end
            step();
        end

        finish_tb();
    end

endmodule

// File: doc/vga_scan_driver.md
# vga_scan_driver

Raster timing generator and pixel output stage for the 640x480 @ 60 Hz display path. It runs on the pixel clock and scans `CurrentX`/`CurrentY` out to the room map modules. It takes each module's registered `mapData` colour back, aligns it with delayed sync and blanking, and drives the 8-bit RRRGGGBB VGA pins. It is the counterpart to every room map block: they consume coordinates and return a colour, and this block issues the coordinates and consumes the colour.

## Interface
Parameters:
- `MAP_LATENCY`, default 1: clock cycles from `CurrentX`/`CurrentY` to a valid `mapData`. Legal range 1–3.
- `H_VIS`, `H_FP`, `H_SYNC`, `H_BP`, default 640/16/96/48: horizontal timing, in pixels.
- `V_VIS`, `V_FP`, `V_SYNC`, `V_BP`, default 480/10/2/33: vertical timing, in lines.

Ports:
- `clk_vga`, in, 1: 25 MHz pixel clock. This is the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `CurrentX`, out, 10: horizontal pixel coordinate to the map modules.
- `CurrentY`, out, 9: vertical pixel coordinate to the map modules.
- `mapData`, in, 8: colour returned by the map module, RRRGGGBB.
- `hsync`, out, 1: horizontal sync, active low.
- `vsync`, out, 1: vertical sync, active low.
- `red`, out, 3: `mapData[7:5]` during the visible area, otherwise 0.
- `green`, out, 3: `mapData[4:2]` during the visible area, otherwise 0.
- `blue`, out, 2: `mapData[1:0]` during the visible area, otherwise 0.
- `frame_start`, out, 1: one-cycle pulse on the first visible pixel of each frame, aligned to the RGB pins.

## Operation
- Internal `hcount` (10 bits) counts 0 to H_TOTAL−1, where H_TOTAL = 800.
  - `hcount` wraps to 0 after 799.
  - `vcount` increments on that same cycle.
- Internal `vcount` (10 bits) counts 0 to V_TOTAL−1, where V_TOTAL = 525, and wraps to 0 after 524.
- `CurrentX` and `CurrentY` are registered outputs.
  - `CurrentX` = `hcount` (0–799).
  - `CurrentY` = `vcount[8:0]` while `vcount` < 480. During vertical blanking it is forced to 0, so the 9-bit output never aliases.
- Raw strobes are decoded from the counters on the same cycle as the coordinates:
  - `vis` is high when `hcount` < 640 and `vcount` < 480.
  - `hs_n` is low when 656 ≤ `hcount` ≤ 751.
  - `vs_n` is low when 490 ≤ `vcount` ≤ 491.
  - `fs` is high when `hcount` = 0 and `vcount` = 0.
- `vis`, `hs_n`, `vs_n` and `fs` pass through a MAP_LATENCY-stage shift register. At the output of that shift register they are aligned with `mapData`.
- The output register captures the aligned signals:
  - `{red,green,blue}` = aligned `vis` ? `mapData` : 8'h00.
  - `hsync` = aligned `hs_n`; `vsync` = aligned `vs_n`; `frame_start` = aligned `fs`.
- The block has no other states: the counters form the only state machine (visible → front porch → sync → back porch, in each axis).

## Timing
- Reset values, applied at the first clock edge with `rst` high:
  - `hcount`, `vcount`, `CurrentX` and `CurrentY` are 0.
  - Every shift-register stage holds `vis`=0, `hs_n`=1, `vs_n`=1, `fs`=0.
  - `hsync` = 1, `vsync` = 1, RGB = 0, `frame_start` = 0.
- While `rst` is high, all outputs hold their reset values.
- The first clock after `rst` falls presents `CurrentX`=0, `CurrentY`=0.
- The pixel at coordinate (x,y) appears on the RGB pins MAP_LATENCY+1 cycles after that coordinate is presented. Sync and `frame_start` carry the same delay.
- Line period is 800 cycles. Frame period is 420000 cycles.
- `hsync` is low for exactly 96 cycles per line. `vsync` is low for exactly 2 lines (1600 cycles). `vsync` edges coincide with the edges of `hcount`-derived timing at `hcount`=0, delayed by the pipeline.
- At the end-of-frame wrap (`hcount`=799, `vcount`=524), both counters return to 0 on the same edge.
- Reset asserted mid-frame: the pipeline is flushed. The output shows blank and inactive sync immediately on the next edge. No partial stale pixel is emitted after `rst` falls.
- `mapData` is ignored whenever aligned `vis` is 0.

## Test plan
- Reset check: hold `rst` for 3 cycles mid-line (`hcount`=300). Required: on the next edge, `hsync`=1, `vsync`=1, RGB=0, `CurrentX`=0. After release, `CurrentX` reads 0,1,2,… on successive cycles.
- Line timing (MAP_LATENCY=1): measure from `CurrentX`=656 to the `hsync` falling edge. Required: the edge arrives 2 cycles later. `hsync` stays low for 96 cycles, and the period between falling edges is 800 cycles.
- Frame timing: run 2 frames. Required: `vsync` is low for 1600 cycles, `frame_start` pulses every 420000 cycles, and `CurrentY` holds 0 throughout `vcount` 480–524.
- Colour pass-through: model the map module as a register returning 8'b10110110 in the visible area. Required: `red`=3'b101, `green`=3'b101, `blue`=2'b10 from the cycle after `frame_start` alignment through pixel 639.
- Blanking: tie `mapData`=8'hFF. Required: RGB=0 for every cycle outside the 640x480 visible area, including the first MAP_LATENCY+1 cycles after reset.
- Latency parameter: set MAP_LATENCY=3 and drive the pattern `mapData` = registered-3 copy of `CurrentX[7:0]`. Required: the RGB byte equals (x mod 256) in visible pixel x, for x = 0–639.
